// File: rtl/ntt_result_unloader.sv
// Captures the NTT wrapper's bit-reversed two-lane result writes into two banks,
// then streams the polynomial out in natural order over valid/ready.
`timescale 1ns/1ps
module ntt_result_unloader #(
  parameter int LOGQ = 64,
  parameter int LOGN = 12,
  parameter int AW   = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   wr_addr,
  input  logic            wr_en,
  input  logic [LOGQ-1:0] wr_data_0,
  input  logic [LOGQ-1:0] wr_data_1,
  input  logic            src_finish,
  output logic [LOGQ-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            done,
  output logic            err
);
  localparam int HALF = 1 << (LOGN - 1);
  localparam int N    = 1 << LOGN;
  localparam logic [LOGN-1:0] WLAST = LOGN'(HALF - 1);
  localparam logic [LOGN:0]   RLAST = (LOGN+1)'(N - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [LOGN-1:0]   wcnt_q, wcnt_d;
  logic [LOGN:0]     rp_q, rp_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              mem_we, issue, pop;
  logic [2:0]        occ;

  logic [LOGQ-1:0]   bank0 [HALF];
  logic [LOGQ-1:0]   bank1 [HALF];
  logic [LOGQ-1:0]   rd_data_q;
  logic              rd_vld_q, rd_last_q;

  logic [LOGQ-1:0]   fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              wptr_q, rptr_q;
  logic [1:0]        cnt_q;

  // Upper address bits beyond the bank index are don't-care from the wrapper.
  logic [AW+LOGN-1:0] waddr_ext;
  logic               unused_waddr;
  assign waddr_ext    = {{LOGN{1'b0}}, wr_addr};
  assign unused_waddr = ^waddr_ext[AW+LOGN-1:LOGN-1];

  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = m_valid ? fifo_data_q[rptr_q] : '0;
  assign m_last  = m_valid & fifo_last_q[rptr_q];
  assign done    = done_q;
  assign err     = err_q;
  assign pop     = m_valid & m_ready;

  // Entries held or in flight after this cycle's pop; keeps the skid from overflowing.
  assign occ   = {1'b0, cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign issue = (state_q == DRAIN) && !rp_q[LOGN] && (occ < 3'd2);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rp_d    = rp_q;
    err_d   = err_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          mem_we  = 1'b1;
          wcnt_d  = LOGN'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (wr_en) begin
          mem_we = 1'b1;
          if (wcnt_q == WLAST) begin
            wcnt_d  = '0;
            rp_d    = '0;
            state_d = DRAIN;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end else if (src_finish) begin
          err_d = 1'b1;
        end
      end
      DRAIN: begin
        if (wr_en) err_d = 1'b1;
        if (issue) rp_d = rp_q + 1'b1;
        if (pop && m_last) begin
          done_d  = 1'b1;
          rp_d    = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      rp_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rp_q    <= rp_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Bank write and registered read (stage p0 -> p1).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      bank0[waddr_ext[LOGN-2:0]] <= wr_data_0;
      bank1[waddr_ext[LOGN-2:0]] <= wr_data_1;
    end
    if (issue) begin
      rd_data_q <= rp_q[LOGN-1] ? bank1[rp_q[LOGN-2:0]] : bank0[rp_q[LOGN-2:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_vld_q  <= issue;
      rd_last_q <= issue && (rp_q == RLAST);
    end
  end

  // Two-entry skid buffer feeding the output (stage p1 -> p2).
  always_ff @(posedge clk) begin
    if (rd_vld_q) fifo_data_q[wptr_q] <= rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_last_q <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (rd_vld_q) begin
        fifo_last_q[wptr_q] <= rd_last_q;
        wptr_q              <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_ntt_result_unloader.sv
// Scoreboard bench for ntt_result_unloader at LOGN=4 (N=16).
`timescale 1ns/1ps
module tb_ntt_result_unloader;
  localparam int LOGQ = 64;
  localparam int LOGN = 4;
  localparam int AW   = 10;
  localparam int N    = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   wr_addr = '0;
  logic            wr_en = 1'b0;
  logic [LOGQ-1:0] wr_data_0 = '0;
  logic [LOGQ-1:0] wr_data_1 = '0;
  logic            src_finish = 1'b0;
  logic [LOGQ-1:0] m_data;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic            m_last;
  logic            done;
  logic            err;

  ntt_result_unloader #(.LOGQ(LOGQ), .LOGN(LOGN), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_data_0(wr_data_0), .wr_data_1(wr_data_1), .src_finish(src_finish),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] d; logic l; } exp_t;
  exp_t sb[$];

  int passed = 0;
  int total  = 0;
  int hs_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready pattern generator: 1,0,0,1 repeating when backpressure is enabled.
  logic       bp_mode = 1'b0;
  logic [3:0] pat = 4'b1001;
  int         ph = 0;
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      m_ready = pat[ph % 4];
      ph++;
    end else begin
      m_ready = 1'b1;
    end
  end

  // Monitor: pops on each handshake, checks stalls and the done pulse.
  logic        stall_prev = 1'b0;
  logic [63:0] hold_data = '0;
  logic        hold_last = 1'b0;
  logic        exp_done = 1'b0;
  always @(negedge clk) begin
    logic nd;
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
      exp_done   = 1'b0;
    end else begin
      nd = 1'b0;
      if (exp_done || done) chk("done_pulse", done, exp_done);
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1'b1);
        chk("stall_data", m_data, hold_data);
        chk("stall_last", m_last, hold_last);
      end
      if (m_valid && m_ready) begin
        hs_count++;
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_output: got %h with no word outstanding", m_data);
        end else begin
          e = sb.pop_front();
          chk("data", m_data, e.d);
          chk("last", m_last, e.l);
          nd = e.l;
        end
      end
      stall_prev = m_valid && !m_ready;
      hold_data  = m_data;
      hold_last  = m_last;
      exp_done   = nd;
    end
  end

  task automatic push_poly(input logic [63:0] b0, input logic [63:0] b1);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.d = (i < N/2) ? b0 + 64'(i) : b1 + 64'(i - N/2);
      e.l = (i == N-1);
      sb.push_back(e);
    end
  endtask

  task automatic fill(input int k0, input int k1, input logic [63:0] b0, input logic [63:0] b1);
    logic [2:0] kk, a;
    for (int k = k0; k <= k1; k++) begin
      kk = k[2:0];
      a  = {kk[0], kk[1], kk[2]};
      wr_addr   = AW'(a);
      wr_data_0 = b0 + 64'(a);
      wr_data_1 = b1 + 64'(a);
      wr_en     = 1'b1;
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      tick();
      cyc++;
    end
    if (!done) chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    int base;
    // Reset state
    tick();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_m_data", m_data, 64'h0);
    rst = 1'b0;
    tick();

    // Wrapper-order fill, ready held high, latency and throughput
    push_poly(64'h100, 64'h200);
    fill(0, 7, 64'h100, 64'h200);
    tick();
    chk("lat_e1_valid", m_valid, 1'b0);
    tick();
    chk("lat_e2_valid", m_valid, 1'b1);
    wait_done(100, cyc);
    chk("drain_cycles", 64'(cyc + 2), 64'(N + 2));
    chk("t1_err", err, 1'b0);
    tick();
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure
    push_poly(64'h100, 64'h200);
    bp_mode = 1'b1;
    fill(0, 7, 64'h100, 64'h200);
    wait_done(200, cyc);
    tick();
    bp_mode = 1'b0;
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);
    chk("bp_err", err, 1'b0);

    // Early finish flags err, drain still completes
    do_reset();
    push_poly(64'h100, 64'h200);
    fill(0, 4, 64'h100, 64'h200);
    src_finish = 1'b1;
    tick();
    src_finish = 1'b0;
    chk("early_err", err, 1'b1);
    fill(5, 7, 64'h100, 64'h200);
    wait_done(100, cyc);
    tick();
    chk("early_sb_empty", 64'(sb.size()), 64'd0);

    // Writes during drain are dropped
    do_reset();
    chk("wd_err_clear", err, 1'b0);
    push_poly(64'h100, 64'h200);
    fill(0, 7, 64'h100, 64'h200);
    wr_addr = '0; wr_data_0 = 64'hDEAD; wr_data_1 = 64'hDEAD; wr_en = 1'b1;
    tick();
    wr_addr = AW'(7);
    tick();
    wr_en = 1'b0;
    chk("wd_err", err, 1'b1);
    wait_done(100, cyc);
    tick();
    chk("wd_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of a drain
    do_reset();
    push_poly(64'h100, 64'h200);
    base = hs_count;
    fill(0, 7, 64'h100, 64'h200);
    cyc = 0;
    while ((hs_count - base) < 6 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("mid_hs_reached", 64'(hs_count - base), 64'd6);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", m_valid, 1'b0);
    chk("mid_rst_last", m_last, 1'b0);
    sb.delete();
    tick();
    chk("mid_rst_done", done, 1'b0);
    tick();
    rst = 1'b0;
    push_poly(64'h500, 64'h600);
    fill(0, 7, 64'h500, 64'h600);
    wait_done(100, cyc);
    tick();
    chk("mid_sb_empty", 64'(sb.size()), 64'd0);

    // Back-to-back polynomials
    push_poly(64'h100, 64'h200);
    fill(0, 7, 64'h100, 64'h200);
    wait_done(100, cyc);
    chk("b2b_done1", done, 1'b1);
    push_poly(64'h300, 64'h400);
    fill(0, 7, 64'h300, 64'h400);
    wait_done(100, cyc);
    tick();
    tick();
    chk("b2b_sb_empty", 64'(sb.size()), 64'd0);
    chk("b2b_done_low", done, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
